// File: rtl/fsqrt_exec_unit.sv
// ============================================================================
// fsqrt_exec_unit : multicycle FSQRT.S execution wrapper with 2-entry CDB FIFO
// Revision: 1.0
// ============================================================================
`default_nettype none

module fsqrt_exec_unit #(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 6,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_operand,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic [4:0]       out_fflags,
   output logic             busy
);

   localparam logic [XLEN-1:0] C_QNAN    = 32'h7FC0_0000;
   localparam logic [XLEN-1:0] C_PINF    = 32'h7F80_0000;
   localparam logic [3:0]      C_CNT_INI = 4'(LATENCY - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [XLEN-1:0]    r_operand;
   logic [TAG_W-1:0]   r_tag;

   logic [XLEN-1:0]    r_buf_res [2];
   logic [TAG_W-1:0]   r_buf_tag [2];
   logic [4:0]         r_buf_flg [2];
   logic               r_wptr;
   logic               r_rptr;
   logic [1:0]         r_count;

   logic               w_accept;
   logic               w_pop;
   logic               w_push;

   logic [30:0]        w_core_mag;
   logic [XLEN-1:0]    w_res;
   logic [4:0]         w_flags;

   // Square-root core, fed only from the held operand (multicycle path)
   always_comb begin : core
      logic [47:0] w_rad;
      logic [27:0] w_rem;
      logic [27:0] w_trial;
      logic [23:0] w_root;
      logic [7:0]  w_cexp;
      logic        w_rnd;
      w_rad  = r_operand[23] ? {1'b0, 1'b1, r_operand[22:0], 23'b0}
                             : {1'b1, r_operand[22:0], 24'b0};
      w_rem  = '0;
      w_root = '0;
      for (int i = 23; i >= 0; i--) begin
         w_rem   = {w_rem[25:0], w_rad[2*i +: 2]};
         w_trial = {2'b00, w_root, 2'b01};
         if (w_rem >= w_trial) begin
            w_rem  = w_rem - w_trial;
            w_root = {w_root[22:0], 1'b1};
         end else begin
            w_root = {w_root[22:0], 1'b0};
         end
      end
      // Remainder above the root means the true root lies past the midpoint
      w_rnd      = (w_rem > {4'b0, w_root});
      w_cexp     = {1'b0, r_operand[30:24]} + 8'd63 + {7'b0, r_operand[23]};
      w_core_mag = {w_cexp, w_root[22:0]} + {30'b0, w_rnd};
   end

   always_comb begin
      w_res   = {1'b0, w_core_mag};
      w_flags = 5'b0;
      if (r_operand[30:23] == 8'hFF && r_operand[22:0] != 23'b0) begin
         w_res   = C_QNAN;
         w_flags = {~r_operand[22], 4'b0};
      end else if (r_operand[30:23] == 8'h00) begin
         // Zeros pass through; denormals flush to a zero of the same sign
         w_res = {r_operand[31], 31'b0};
      end else if (r_operand[31]) begin
         w_res   = C_QNAN;
         w_flags = 5'b10000;
      end else if (r_operand[30:23] == 8'hFF) begin
         w_res = C_PINF;
      end
   end

   assign in_ready = (r_state == S_IDLE);
   assign w_accept = in_ready && in_valid && !flush;
   assign out_valid = (r_count != 2'd0);
   assign w_pop    = out_valid && out_ready;
   assign w_push   = (r_state == S_BUSY) && (r_cnt == 4'd0) && !flush &&
                     ((r_count != 2'd2) || w_pop);
   assign busy     = (r_state != S_IDLE) || (r_count != 2'd0);

   assign out_result = out_valid ? r_buf_res[r_rptr] : '0;
   assign out_tag    = out_valid ? r_buf_tag[r_rptr] : '0;
   assign out_fflags = out_valid ? r_buf_flg[r_rptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_push)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_operand <= '0;
         r_tag     <= '0;
      end else if (w_accept) begin
         r_cnt     <= C_CNT_INI;
         r_operand <= in_operand;
         r_tag     <= in_tag;
      end else if (flush) begin
         r_cnt <= '0;
      end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_res[0] <= '0;
         r_buf_res[1] <= '0;
         r_buf_tag[0] <= '0;
         r_buf_tag[1] <= '0;
         r_buf_flg[0] <= '0;
         r_buf_flg[1] <= '0;
         r_wptr       <= 1'b0;
         r_rptr       <= 1'b0;
         r_count      <= 2'd0;
      end else if (flush) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_push) begin
            r_buf_res[r_wptr] <= w_res;
            r_buf_tag[r_wptr] <= r_tag;
            r_buf_flg[r_wptr] <= w_flags;
            r_wptr            <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fsqrt_exec_unit.sv
// ============================================================================
// tb_fsqrt_exec_unit : directed and randomized checks for fsqrt_exec_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fsqrt_exec_unit;

   localparam int XLEN    = 32;
   localparam int TAG_W   = 6;
   localparam int LATENCY = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_operand;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic [4:0]       out_fflags;
   logic             busy;

   int total = 0;
   int bad   = 0;

   fsqrt_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_operand (in_operand),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag),
      .out_fflags (out_fflags),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: IEEE special cases, otherwise double-precision sqrt rounded
   // to nearest single (double rounding is exact for sqrt at these widths).
   function automatic logic [36:0] ref_sqrt(input logic [31:0] a);
      logic [7:0]  e;
      logic [22:0] m;
      int          de;
      int          fe;
      real         x;
      real         r;
      logic [63:0] d;
      logic        up;
      logic [31:0] res;
      e = a[30:23];
      m = a[22:0];
      if (e == 8'hFF && m != 23'b0) return {~m[22], 4'b0, 32'h7FC00000};
      if (e == 8'h00) return {5'b0, a[31], 31'b0};
      if (a[31]) return {5'b10000, 32'h7FC00000};
      if (e == 8'hFF) return {5'b0, 32'h7F800000};
      de  = int'(e) - 127 + 1023;
      x   = $bitstoreal({1'b0, de[10:0], m, 29'b0});
      r   = $sqrt(x);
      d   = $realtobits(r);
      fe  = int'(d[62:52]) - 1023 + 127;
      up  = d[28] && ((d[27:0] != 28'b0) || d[29]);
      res = {1'b0, fe[7:0], d[51:29]} + {31'b0, up};
      return {5'b0, res};
   endfunction

   function automatic logic [31:0] rand_operand();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 7))
         0, 1, 2, 3: v[31:23] = {1'b0, 8'($urandom_range(1, 254))};
         4:          begin v[30:23] = 8'hFF; if (v[22:0] == 23'b0) v[0] = 1'b1; end
         5:          v[30:0] = 31'b0;
         6:          begin v[31] = 1'b1; v[30:23] = 8'($urandom_range(1, 255)); if (v[30:23] == 8'hFF) v[22:0] = 23'b0; end
         default:    begin v[31] = 1'b0; if (v[0]) v[30:0] = {8'hFF, 23'b0}; else v[30:23] = 8'h00; end
      endcase
      return v;
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (n >= 50) check(name, 64'(in_ready), 64'd1);
   endtask

   task automatic issue(input logic [31:0] op, input logic [TAG_W-1:0] tag);
      in_valid   = 1'b1;
      in_operand = op;
      in_tag     = tag;
      step();
      in_valid   = 1'b0;
   endtask

   task automatic run_op(input string name, input logic [31:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] eres, input logic [4:0] eflg);
      int n;
      out_ready = 1'b1;
      wait_ready({name, "_ready"});
      issue(op, tag);
      n = 0;
      while (!out_valid && n < 20) begin step(); n++; end
      check({name, "_lat"}, 64'(n), 64'(LATENCY));
      check({name, "_res"}, {27'b0, out_fflags, out_tag, out_result}, {27'b0, eflg, tag, eres});
      step();
   endtask

   initial begin : stim
      logic [42:0] q[$];
      logic [42:0] e;
      int          seen;
      int          done;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_operand = '0; in_tag = '0;
      #12;
      check("reset_outs", {57'b0, in_ready, out_valid, busy, out_fflags[3:0]}, {57'b0, 1'b1, 1'b0, 1'b0, 4'b0});
      check("reset_data", {21'b0, out_fflags, out_tag, out_result}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      step();

      // Directed values and specials
      run_op("sqrt4",   32'h40800000, 6'd5,  32'h40000000, 5'b00000);
      run_op("sqrt2",   32'h40000000, 6'd6,  32'h3FB504F3, 5'b00000);
      run_op("sqrt1",   32'h3F800000, 6'd7,  32'h3F800000, 5'b00000);
      run_op("neg1",    32'hBF800000, 6'd8,  32'h7FC00000, 5'b10000);
      run_op("snan",    32'h7F800001, 6'd9,  32'h7FC00000, 5'b10000);
      run_op("qnan",    32'h7FC00001, 6'd10, 32'h7FC00000, 5'b00000);
      run_op("pinf",    32'h7F800000, 6'd11, 32'h7F800000, 5'b00000);
      run_op("ninf",    32'hFF800000, 6'd12, 32'h7FC00000, 5'b10000);
      run_op("nzero",   32'h80000000, 6'd13, 32'h80000000, 5'b00000);
      run_op("denorm",  32'h00000001, 6'd14, 32'h00000000, 5'b00000);
      run_op("maxnorm", 32'h7F7FFFFF, 6'd15, 32'h5F7FFFFF, 5'b00000);

      // Backpressure: two buffered, third stalls then pushes on first pop
      out_ready = 1'b0;
      wait_ready("bp_r1"); issue(32'h41800000, 6'd1);
      wait_ready("bp_r2"); issue(32'h42C80000, 6'd2);
      wait_ready("bp_r3"); issue(32'h41100000, 6'd3);
      repeat (LATENCY + 2) step();
      check("bp_stall", {61'b0, in_ready, busy, out_valid}, {61'b0, 1'b0, 1'b1, 1'b1});
      check("bp_head1", {26'b0, out_tag, out_result}, {26'b0, 6'd1, 32'h40800000});
      step();
      check("bp_hold1", {26'b0, out_tag, out_result}, {26'b0, 6'd1, 32'h40800000});
      out_ready = 1'b1;
      step();
      check("bp_head2", {25'b0, in_ready, out_tag, out_result}, {25'b0, 1'b1, 6'd2, 32'h41200000});
      step();
      check("bp_head3", {25'b0, out_valid, out_tag, out_result}, {25'b0, 1'b1, 6'd3, 32'h40400000});
      step();
      check("bp_empty", {62'b0, out_valid, busy}, 64'd0);

      // Flush during BUSY
      issue(32'h40800000, 6'd20);
      step();
      flush = 1'b1; step(); flush = 1'b0;
      check("fl1_state", {61'b0, out_valid, busy, in_ready}, {61'b0, 1'b0, 1'b0, 1'b1});
      seen = 0;
      repeat (10) begin if (out_valid) seen++; step(); end
      check("fl1_squash", 64'(seen), 64'd0);

      // Flush with two entries buffered and a same-cycle handshake
      out_ready = 1'b0;
      wait_ready("fl2_r1"); issue(32'h40800000, 6'd21);
      wait_ready("fl2_r2"); issue(32'h41100000, 6'd22);
      wait_ready("fl2_r3");
      check("fl2_full", {57'b0, out_valid, out_tag}, {57'b0, 1'b1, 6'd21});
      flush = 1'b1; in_valid = 1'b1; in_operand = 32'h3F800000; in_tag = 6'd23;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl2_state", {61'b0, out_valid, busy, in_ready}, {61'b0, 1'b0, 1'b0, 1'b1});
      out_ready = 1'b1;
      seen = 0;
      repeat (10) begin if (out_valid) seen++; step(); end
      check("fl2_squash", 64'(seen), 64'd0);

      // Asynchronous reset mid-operation
      issue(32'h40800000, 6'd30);
      step();
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid", {57'b0, in_ready, out_valid, busy, out_fflags[3:0]}, {57'b0, 1'b1, 1'b0, 1'b0, 4'b0});
      check("rst_mid_d", {21'b0, out_fflags, out_tag, out_result}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_op("sqrt9", 32'h41100000, 6'd31, 32'h40400000, 5'b00000);

      // Randomized traffic against the queue-based reference
      done = 0;
      for (int cyc = 0; cyc < 4000 && done < 60; cyc++) begin
         out_ready  = ($urandom_range(0, 3) != 0);
         in_valid   = ($urandom_range(0, 1) == 1);
         in_operand = rand_operand();
         in_tag     = 6'($urandom);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("rand_extra", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               check("rand_res", {21'b0, out_tag, out_fflags, out_result}, {21'b0, e});
            end
            done++;
         end
         if (in_valid && in_ready) q.push_back({in_tag, ref_sqrt(in_operand)});
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 60 && (q.size() != 0 || busy); n++) begin
         if (out_valid) begin
            if (q.size() == 0) begin
               check("drain_extra", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               check("drain_res", {21'b0, out_tag, out_fflags, out_result}, {21'b0, e});
            end
         end
         step();
      end
      check("rand_done", {31'b0, busy, 32'(q.size())}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
